// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: synchronizes and filters the raw lines, frames
// bytes, and folds E0/F0 prefixes into a toggle-flagged key event.
module ps2_key_decoder #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 24576
) (
    input  logic        I_CLK,
    input  logic        I_RESETn,
    input  logic        I_PS2_CLK,
    input  logic        I_PS2_DAT,
    output logic [10:0] O_PS2_KEY,
    output logic        O_ERR
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [1:0]    clk_sync;
    logic [1:0]    dat_sync;
    logic          clk_s;
    logic          dat_s;

    logic [FW-1:0] filt_cnt;
    logic          filt_clk;
    logic          flip;
    logic          fall;

    logic [3:0]    bit_cnt;
    logic [9:0]    shreg;
    logic [10:0]   frame;
    logic          done;
    logic [TW-1:0] to_cnt;
    logic          timeout;

    logic [7:0]    data;
    logic          frame_ok;
    logic          ext;
    logic          brk;

    assign clk_s = clk_sync[1];
    assign dat_s = dat_sync[1];

    // Two-flop synchronizers, idle-high after reset
    always_ff @(posedge I_CLK or negedge I_RESETn) begin
        if (!I_RESETn) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
        end else begin
            clk_sync <= {clk_sync[0], I_PS2_CLK};
            dat_sync <= {dat_sync[0], I_PS2_DAT};
        end
    end

    // The filtered clock flips on the FILTER_LEN-th cycle of a new level
    assign flip = (clk_s != filt_clk) &&
                  (filt_cnt == FW'(FILTER_LEN - 1));
    assign fall = flip && filt_clk;

    // Glitch filter on the synchronized PS/2 clock
    always_ff @(posedge I_CLK or negedge I_RESETn) begin
        if (!I_RESETn) begin
            filt_cnt <= '0;
            filt_clk <= 1'b1;
        end else if (clk_s == filt_clk) begin
            filt_cnt <= '0;
        end else if (flip) begin
            filt_clk <= clk_s;
            filt_cnt <= '0;
        end else begin
            filt_cnt <= filt_cnt + 1'b1;
        end
    end

    // Abort only when a frame is open and no edge arrived in time
    assign timeout = (bit_cnt != 4'd0) && !fall &&
                     (to_cnt == TW'(TIMEOUT_CYCLES - 1));

    // Bit framing: shift LSB first, hand the full frame over after the stop bit
    always_ff @(posedge I_CLK or negedge I_RESETn) begin
        if (!I_RESETn) begin
            bit_cnt <= 4'd0;
            shreg   <= '0;
            frame   <= '0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (fall) begin
                if (bit_cnt == 4'd10) begin
                    frame   <= {dat_s, shreg};
                    done    <= 1'b1;
                    bit_cnt <= 4'd0;
                end else begin
                    shreg   <= {dat_s, shreg[9:1]};
                    bit_cnt <= bit_cnt + 4'd1;
                end
            end else if (timeout) begin
                bit_cnt <= 4'd0;
            end
        end
    end

    // Inter-edge timer, held at zero while idle
    always_ff @(posedge I_CLK or negedge I_RESETn) begin
        if (!I_RESETn) begin
            to_cnt <= '0;
        end else if (fall || bit_cnt == 4'd0 || timeout) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    assign data     = frame[8:1];
    assign frame_ok = !frame[0] && frame[10] && (^frame[9:1]);

    // Byte interpretation: prefixes, ignored responses, and key events
    always_ff @(posedge I_CLK or negedge I_RESETn) begin
        if (!I_RESETn) begin
            O_PS2_KEY <= 11'h000;
            O_ERR     <= 1'b0;
            ext       <= 1'b0;
            brk       <= 1'b0;
        end else begin
            O_ERR <= 1'b0;
            if (timeout) begin
                ext   <= 1'b0;
                brk   <= 1'b0;
                O_ERR <= 1'b1;
            end else if (done) begin
                if (!frame_ok) begin
                    ext   <= 1'b0;
                    brk   <= 1'b0;
                    O_ERR <= 1'b1;
                end else begin
                    case (data)
                        8'hE0: ext <= 1'b1;
                        8'hF0: brk <= 1'b1;
                        8'hE1, 8'hAA, 8'hEE, 8'hFA,
                        8'hFE, 8'h00, 8'hFF: begin
                            ext <= 1'b0;
                            brk <= 1'b0;
                        end
                        default: begin
                            O_PS2_KEY <= {~O_PS2_KEY[10], ~brk, ext, data};
                            ext       <= 1'b0;
                            brk       <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: doc/ps2_key_decoder.md
PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

Interface
REQ-001 SHALL have parameter FILTER_LEN, default 8: consecutive I_CLK cycles of a stable synchronized PS/2 clock level required before the filtered level changes.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 24576: maximum I_CLK cycles allowed between falling edges inside a frame (1 ms at 24.576 MHz).
REQ-003 SHALL have port I_CLK, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-004 SHALL have port I_RESETn, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port I_PS2_CLK, input, 1 bit: raw PS/2 clock line, asynchronous to I_CLK.
REQ-006 SHALL have port I_PS2_DAT, input, 1 bit: raw PS/2 data line, asynchronous to I_CLK.
REQ-007 SHALL have port O_PS2_KEY, output, 11 bits: [10] event toggle, [9] pressed (1=make, 0=break), [8] extended (E0 prefix), [7:0] scancode.
REQ-008 SHALL have port O_ERR, output, 1 bit: one-cycle pulse on a discarded frame.

Function
REQ-009 SHALL pass I_PS2_CLK and I_PS2_DAT through two-flop synchronizers before any other use.
REQ-010 SHALL change the filtered clock only after the synchronized clock has held the new level for FILTER_LEN consecutive cycles; shorter pulses are ignored.
REQ-011 SHALL sample the synchronized data on each 1->0 transition of the filtered clock, advancing a bit counter 0..10.
REQ-012 SHALL use this frame layout: bit 0 start (must be 0), bits 1-8 data LSB first, bit 9 odd parity over the data, bit 10 stop (must be 1).
REQ-013 SHALL treat a frame as valid only when start=0, parity is odd and stop=1; after the 11th sample the counter returns to 0.
REQ-014 SHALL, on an invalid frame, discard the byte, clear the ext and brk prefix flags, and assert O_ERR for exactly one cycle, the cycle after the stop sample.
REQ-015 SHALL abort a frame when the bit counter is nonzero and TIMEOUT_CYCLES pass with no falling edge: counter to 0, prefix flags cleared, O_ERR pulsed for one cycle.
REQ-016 SHALL treat an idle timeout (counter = 0) as no event and never pulse O_ERR for it.
REQ-017 SHALL handle a valid byte 0xE0 by setting ext, with no output change.
REQ-018 SHALL handle a valid byte 0xF0 by setting brk, with no output change.
REQ-019 SHALL handle valid bytes 0xE1, 0xAA, 0xEE, 0xFA, 0xFE, 0x00 and 0xFF (device responses and pause prefix) by clearing ext and brk, with no output change.
REQ-020 SHALL handle any other valid byte by registering O_PS2_KEY[7:0] = byte, [8] = ext, [9] = ~brk and [10] = inverted previous [10], then clearing ext and brk.
REQ-021 SHALL make O_PS2_KEY update, and O_ERR assert, on the I_CLK edge immediately after the edge that captured the stop-bit sample, so latency is exactly 1 cycle.
REQ-022 SHALL let O_PS2_KEY[10] change at most once per valid frame; it is the only "new event" indication and there is no strobe.
REQ-023 SHALL accept an E0 followed by F0 in either order, in any combination, before the final scancode.
REQ-024 SHALL hold O_PS2_KEY stable between events; a timeout or error never alters O_PS2_KEY.

Reset
REQ-025 SHALL, when I_RESETn=0, immediately set O_PS2_KEY=11'h000 and O_ERR=0, clear ext and brk, set the bit counter to 0, set the filtered clock to 1, preload synchronizers to 1, and clear the timeout and filter counters.
REQ-026 SHALL discard any frame in progress when reset asserts mid-frame; after release, decoding restarts at the next start bit with no O_ERR.

Verification
REQ-027 SHALL pass: after reset, one frame of 0x1C (parity 0, stop 1) at a 12 kHz PS/2 clock -> O_PS2_KEY = 11'h61C one cycle after the stop sample, and O_ERR stays 0.
REQ-028 SHALL pass: continuing, frames F0 then 1C -> O_PS2_KEY stays 11'h61C after F0, then becomes 11'h01C.
REQ-029 SHALL pass: continuing, frames E0 then 75 -> O_PS2_KEY = 11'h775.
REQ-030 SHALL pass: frame 0x1C with the parity bit inverted -> one-cycle O_ERR pulse and O_PS2_KEY unchanged; a following good 0x1C toggles bit 10.
REQ-031 SHALL pass: 5 bits sent, then the line held idle for TIMEOUT_CYCLES+10 -> exactly one O_ERR pulse; a subsequent full 0x29 frame decodes correctly with no misalignment.
REQ-032 SHALL pass: a 3-cycle low glitch on I_PS2_CLK while idle, and a mid-frame glitch of FILTER_LEN-1 cycles -> no extra sample, and the frame decodes correctly.
